// File: rtl/irrigation_actuator_ctrl.sv
// irrigation_actuator_ctrl
//   Sequences the field actuators from the irrigation decision flags:
//   pump priming, a timed valve run bounded by min/max run times, and a
//   pump-off drain. A critical water level forces a lockout from any state.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   sprinkler_req     sprinkler request (level)
//   drip_req          drip request (level)
//   water_box[1:0]    tank level: 00 critical, 01 low, 10 medium, 11 high
//   pump_en           pump motor enable
//   sprinkler_valve   sprinkler valve open
//   drip_valve        drip valve open
//   busy              controller not idle
//   fault             low-water lockout active
//   run_done          one-cycle pulse after a run drains normally
//
// Optional feature (macro IRRIG_RUN_STATS_EN):
//   run_count[15:0]         completed runs, wraps
//   last_run_len[CNT_W-1:0] RUN cycle count of the last completed run
module irrigation_actuator_ctrl #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned PRIME_CYC  = 8,
  parameter int unsigned MIN_ON_CYC = 32,
  parameter int unsigned MAX_ON_CYC = 200,
  parameter int unsigned DRAIN_CYC  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sprinkler_req,
  input  logic             drip_req,
  input  logic [1:0]       water_box,
  output logic             pump_en,
  output logic             sprinkler_valve,
  output logic             drip_valve,
  output logic             busy,
  output logic             fault,
  output logic             run_done
`ifdef IRRIG_RUN_STATS_EN
  ,
  output logic [15:0]      run_count,
  output logic [CNT_W-1:0] last_run_len
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DRAIN,
    S_LOCKOUT
  } state_t;

  localparam logic [CNT_W-1:0] PRIME_LAST = CNT_W'(PRIME_CYC - 1);
  localparam logic [CNT_W-1:0] MIN_LAST   = CNT_W'(MIN_ON_CYC - 1);
  localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_ON_CYC - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q, mode_d;   // 1 = sprinkler, 0 = drip
  logic             run_done_q;
  logic             critical;
  logic             mode_req;

  assign critical = (water_box == 2'b00);
  assign mode_req = mode_q ? sprinkler_req : drip_req;

  // Critical level is tested first in every active state so it beats
  // all other transitions.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (critical) begin
          state_d = S_LOCKOUT;
        end else if (sprinkler_req || drip_req) begin
          mode_d  = sprinkler_req;
          state_d = S_PRIME;
        end
      end
      S_PRIME: begin
        if (critical)                state_d = S_LOCKOUT;
        else if (cnt_q == PRIME_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        if (critical)
          state_d = S_LOCKOUT;
        else if ((cnt_q == MAX_LAST) || ((cnt_q >= MIN_LAST) && !mode_req))
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (critical)                 state_d = S_LOCKOUT;
        else if (cnt_q == DRAIN_LAST) state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (!critical) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      run_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      cnt_q      <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      run_done_q <= (state_q == S_DRAIN) && (state_d == S_IDLE);
    end
  end

  always_comb begin
    pump_en         = (state_q == S_PRIME) || (state_q == S_RUN);
    sprinkler_valve = ((state_q == S_RUN) || (state_q == S_DRAIN)) && mode_q;
    drip_valve      = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !mode_q;
    busy            = (state_q != S_IDLE);
    fault           = (state_q == S_LOCKOUT);
    run_done        = run_done_q;
  end

`ifdef IRRIG_RUN_STATS_EN
  logic [15:0]      run_count_q;
  logic [CNT_W-1:0] last_run_len_q;
  logic [CNT_W-1:0] run_len_q;

  // The run length is held aside at RUN exit and only committed when the
  // drain completes, so a lockout during DRAIN leaves the stats untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_count_q    <= '0;
      last_run_len_q <= '0;
      run_len_q      <= '0;
    end else begin
      if ((state_q == S_RUN) && (state_d == S_DRAIN))
        run_len_q <= cnt_q + CNT_W'(1);
      if ((state_q == S_DRAIN) && (state_d == S_IDLE)) begin
        run_count_q    <= run_count_q + 16'd1;
        last_run_len_q <= run_len_q;
      end
    end
  end

  assign run_count    = run_count_q;
  assign last_run_len = last_run_len_q;
`endif

endmodule

// File: tb/tb_irrigation_actuator_ctrl.sv
// Scoreboard bench for irrigation_actuator_ctrl with
// PRIME=4, MIN_ON=8, MAX_ON=20, DRAIN=3. Stimulus pushes per-cycle expected
// output vectors {pump, sprinkler_valve, drip_valve, busy, fault, run_done}
// stamped with the cycle they apply to; the monitor compares at each negedge.
module tb_irrigation_actuator_ctrl;
  localparam int unsigned CNT_W = 8;

  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_PRIME = 6'b100100;
  localparam logic [5:0] O_RUN_S = 6'b110100;
  localparam logic [5:0] O_RUN_D = 6'b101100;
  localparam logic [5:0] O_DRN_S = 6'b010100;
  localparam logic [5:0] O_DRN_D = 6'b001100;
  localparam logic [5:0] O_LOCK  = 6'b000110;
  localparam logic [5:0] O_DONE  = 6'b000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sreq = 1'b0;
  logic       dreq = 1'b0;
  logic [1:0] wb = 2'b11;
  logic       pump_en, sprinkler_valve, drip_valve, busy, fault, run_done;
`ifdef IRRIG_RUN_STATS_EN
  logic [15:0]      run_count;
  logic [CNT_W-1:0] last_run_len;
`endif

  always #5 clk = ~clk;

  irrigation_actuator_ctrl #(
    .CNT_W(CNT_W), .PRIME_CYC(4), .MIN_ON_CYC(8), .MAX_ON_CYC(20), .DRAIN_CYC(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sprinkler_req(sreq), .drip_req(dreq),
    .water_box(wb), .pump_en(pump_en), .sprinkler_valve(sprinkler_valve),
    .drip_valve(drip_valve), .busy(busy), .fault(fault), .run_done(run_done)
`ifdef IRRIG_RUN_STATS_EN
    , .run_count(run_count), .last_run_len(last_run_len)
`endif
  );

  typedef struct {
    int         cyc;
    logic [5:0] v;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [5:0] outs();
    return {pump_en, sprinkler_valve, drip_valve, busy, fault, run_done};
  endfunction

  task automatic check_vec(string tag, int c, logic [5:0] act, logic [5:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d outputs=%b expected=%b", tag, c, act, exp);
    end
  endtask

  // Monitor: pops the entry stamped for the current cycle.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s missed cyc=%0d now=%0d", sb[0].tag, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      check_vec(e.tag, e.cyc, outs(), e.v);
    end
  end

  task automatic push_span(int start, int n, logic [5:0] v, string tag);
    for (int i = 0; i < n; i++) sb.push_back('{start + i, v, tag});
  endtask

  // Full run starting with PRIME at cycle b: 4 prime, run_len run, 3 drain, done pulse.
  task automatic push_run(int b, bit sprk, int run_len, string tag);
    push_span(b, 4, O_PRIME, tag);
    push_span(b + 4, run_len, sprk ? O_RUN_S : O_RUN_D, tag);
    push_span(b + 4 + run_len, 3, sprk ? O_DRN_S : O_DRN_D, tag);
    push_span(b + 7 + run_len, 1, O_DONE, tag);
  endtask

  task automatic tick_to(int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_stats(string tag, int exp_cnt, int exp_len);
`ifdef IRRIG_RUN_STATS_EN
    n_tests++;
    if (run_count !== 16'(exp_cnt) || last_run_len !== CNT_W'(exp_len)) begin
      n_fail++;
      $display("FAIL %s run_count=%0d last_run_len=%0d expected %0d/%0d",
               tag, run_count, last_run_len, exp_cnt, exp_len);
    end
`endif
  endtask

  initial begin
    int b;
    #1;
    check_vec("reset_outputs", cyc, outs(), O_IDLE);
    tick_to(2);
    push_span(2, 3, O_IDLE, "reset_idle");
    rst_n = 1'b1;
    tick_to(4);
    check_stats("reset_stats", 0, 0);

    // 1: one-cycle sprinkler pulse -> minimum-length run
    b = cyc + 1;
    sreq = 1'b1;
    push_run(b, 1'b1, 8, "t1_sprk_pulse");
    push_span(b + 16, 2, O_IDLE, "t1_idle");
    tick_to(b);
    sreq = 1'b0;
    tick_to(b + 17);
    check_stats("t1_stats", 1, 8);

    // 2: drip held -> two max-length runs with one IDLE cycle between
    b = cyc + 1;
    dreq = 1'b1;
    push_run(b, 1'b0, 20, "t2_run1");
    push_run(b + 28, 1'b0, 20, "t2_run2");
    push_span(b + 56, 2, O_IDLE, "t2_idle");
    tick_to(b + 55);
    dreq = 1'b0;
    tick_to(b + 57);
    check_stats("t2_stats", 3, 20);

    // 2c: request drops in the same cycle MAX_ON expires
    b = cyc + 1;
    sreq = 1'b1;
    push_run(b, 1'b1, 20, "t2c_max_and_drop");
    push_span(b + 28, 2, O_IDLE, "t2c_idle");
    tick_to(b + 23);
    sreq = 1'b0;
    tick_to(b + 29);
    check_stats("t2c_stats", 4, 20);

    // 3: both requests -> sprinkler mode; drip alone is ignored in RUN
    b = cyc + 1;
    sreq = 1'b1;
    dreq = 1'b1;
    push_run(b, 1'b1, 8, "t3_both_req");
    push_span(b + 16, 2, O_IDLE, "t3_idle");
    tick_to(b);
    sreq = 1'b0;
    tick_to(b + 13);
    dreq = 1'b0;
    tick_to(b + 17);
    check_stats("t3_stats", 5, 8);

    // 4: critical level at RUN cycle 5 -> lockout, no run_done
    b = cyc + 1;
    sreq = 1'b1;
    push_span(b, 4, O_PRIME, "t4_prime");
    push_span(b + 4, 6, O_RUN_S, "t4_run");
    push_span(b + 10, 3, O_LOCK, "t4_lockout");
    push_span(b + 13, 2, O_IDLE, "t4_idle");
    tick_to(b + 9);
    wb = 2'b00;
    tick_to(b + 12);
    wb = 2'b01;
    sreq = 1'b0;
    tick_to(b + 14);
    check_stats("t4_stats", 5, 8);

    // 4b: critical level in IDLE beats a pending request
    b = cyc;
    wb = 2'b00;
    dreq = 1'b1;
    push_span(b + 1, 2, O_LOCK, "t4b_idle_lockout");
    push_span(b + 3, 2, O_IDLE, "t4b_idle");
    tick_to(b + 2);
    wb = 2'b10;
    dreq = 1'b0;
    tick_to(b + 4);

    // 5: asynchronous reset mid-RUN, between clock edges
    b = cyc + 1;
    wb = 2'b11;
    sreq = 1'b1;
    push_span(b, 4, O_PRIME, "t5_prime");
    push_span(b + 4, 2, O_RUN_S, "t5_run");
    push_span(b + 6, 5, O_IDLE, "t5_after_reset");
    tick_to(b + 6);
    #2;
    rst_n = 1'b0;
    #1;
    check_vec("t5_async_reset", cyc, outs(), O_IDLE);
    sreq = 1'b0;
    tick_to(b + 7);
    #3;
    rst_n = 1'b1;
    tick_to(b + 10);
    check_stats("t5_stats", 0, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
